// File: rtl/dz_countdown.sv
// dz_countdown: key-driven START_VAL..0 countdown timer for the dot-matrix display stage.
// Two raw keys (start/restart, pause/resume) are synchronized and edge-detected into
// single-cycle events that drive an IDLE/RUN/PAUSE/DONE controller with a TICK_DIV prescaler.
// Optional feature: define KEY_DEBOUNCE_EN to insert a per-key DB_CYCLES stable-time filter
// between the synchronizer and the edge detector.
module dz_countdown #(
    parameter int unsigned TICK_DIV  = 1000,
    parameter logic [2:0]  START_VAL = 3'd5,
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_key,
    input  logic       pause_key,
    output logic [2:0] num,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned KEYS  = 2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Elaboration-time parameter range checks
    if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_tick_div_check
        $error("dz_countdown: TICK_DIV must be 2..65535");
    end
    if (START_VAL < 3'd1 || START_VAL > 3'd5) begin : g_start_val_check
        $error("dz_countdown: START_VAL must be 1..5");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_db_cycles_check
        $error("dz_countdown: DB_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit 0 = start key, bit 1 = pause key
    logic [KEYS-1:0] sync1;
    logic [KEYS-1:0] sync2;
    logic [KEYS-1:0] lvl_c;
    logic [KEYS-1:0] prev;
    logic [KEYS-1:0] ev;
    logic [KEYS-1:0] armed;
    logic [1:0]      sync_vld;

    state_t            state;
    logic [DIV_W-1:0]  divider;

    // Two-flop synchronizer, rising-edge detector and post-reset arming.
    // A key only arms once its synchronized level has been seen low after reset, so a
    // key held through reset cannot fire; sync_vld masks the reset zeros still in the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            ev       <= '0;
            armed    <= '0;
            sync_vld <= '0;
        end else begin
            sync1    <= {pause_key, start_key};
            sync2    <= sync1;
            prev     <= lvl_c;
            ev       <= lvl_c & ~prev & armed;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1]) begin
                armed <= armed | ~sync2;
            end
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [KEYS];
    logic [KEYS-1:0] filt;

    // Stable-time filter: the filtered level follows the synchronized level only after
    // DB_CYCLES consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            for (int i = 0; i < KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEYS; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign lvl_c = filt;
`else
    assign lvl_c = sync2;
`endif

    // Countdown controller; start_ev (ev[0]) overrides everything, including pause_ev (ev[1])
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            num     <= START_VAL;
            busy    <= 1'b0;
            done    <= 1'b0;
            divider <= '0;
        end else begin
            done <= 1'b0;
            if (ev[0]) begin
                state   <= RUN;
                num     <= START_VAL;
                divider <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (divider == DIV_LAST) begin
                            // Tick: the step is taken even if a pause arrives on this edge
                            divider <= '0;
                            num     <= num - 3'd1;
                            if (num == 3'd1) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (ev[1]) begin
                                state <= PAUSE;
                            end
                        end else if (ev[1]) begin
                            state <= PAUSE;
                        end else begin
                            divider <= divider + DIV_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (ev[1]) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
